jb_resolve_ras: RTL and testbench

- Parametrised jump/branch resolution stage for the pipelined MIPS core.
- Generalises the combinational JAL detect: decodes the 3-bit JumpBranch code, resolves taken/not-taken and target, and produces a registered redirect.
- Holds a return-address stack (RAS): pushed on JAL, popped on JR. JR is checked against the stack top and reported as hit/miss.
- Sits between ID/EX and the PC-select logic.

---
 rtl/jb_pkg.sv | 14 +
 rtl/jb_ras_stack.sv | 45 ++++
 rtl/jb_resolve_ras.sv | 151 +++++++++++++++
 tb/tb_jb_resolve_ras.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_pkg.sv
// Shared JumpBranch code definitions used by the control unit and the
// jump/branch resolution stage.
package jb_pkg;

   typedef logic [2:0] jb_code_t;

   localparam jb_code_t JB_OTHERS = 3'd0;
   localparam jb_code_t JB_BEQ    = 3'd1;
   localparam jb_code_t JB_BNE    = 3'd2;
   localparam jb_code_t JB_JR     = 3'd3;
   localparam jb_code_t JB_J      = 3'd4;
   localparam jb_code_t JB_JAL    = 3'd7;

endpackage

// File: rtl/jb_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on an empty stack is ignored. o_top is the most recently pushed entry.
module jb_ras_stack #(
   parameter int AW        = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [AW-1:0]                i_din,
   output logic [AW-1:0]                o_top,
   output logic [$clog2(RAS_DEPTH):0]   o_count
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

   logic [AW-1:0] r_mem [RAS_DEPTH];
   logic [PW-1:0] r_ptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_top_idx;

   // r_ptr points at the next free slot; when full it also points at the oldest.
   assign w_top_idx = r_ptr - PW'(1);
   assign o_top     = r_mem[w_top_idx];
   assign o_count   = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= '0;
         r_count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
      end else if (i_push) begin
         r_mem[r_ptr] <= i_din;
         r_ptr        <= r_ptr + PW'(1);
         if (r_count != FULL) r_count <= r_count + CW'(1);
      end else if (i_pop && (r_count != '0)) begin
         r_ptr   <= w_top_idx;
         r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: rtl/jb_resolve_ras.sv
// Jump/branch resolution stage with return-address stack and registered redirect.
// Optional macro JB_STATS_EN adds saturating redirect_cnt / ras_miss_cnt outputs.
module jb_resolve_ras
   import jb_pkg::*;
#(
   parameter int AW          = 32,
   parameter int RAS_DEPTH   = 4,
   parameter int LINK_OFFSET = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic                        stall,
   input  logic                        flush,
   input  logic [2:0]                  jump_branch,
   input  logic [AW-1:0]               pc,
   input  logic                        zero,
   input  logic [AW-1:0]               rs_val,
   input  logic [AW-1:0]               br_target,
   input  logic [AW-1:0]               j_target,
   output logic                        out_valid,
   output logic                        jal,
   output logic                        redirect,
   output logic [AW-1:0]               target,
   output logic [AW-1:0]               link_addr,
   output logic                        ras_hit,
   output logic [$clog2(RAS_DEPTH):0]  ras_count
`ifdef JB_STATS_EN
   ,
   output logic [31:0]                 redirect_cnt,
   output logic [31:0]                 ras_miss_cnt
`endif
);

   localparam int CW = $clog2(RAS_DEPTH) + 1;

   logic          w_accept;
   logic          w_is_jal;
   logic          w_is_jr;
   logic          w_redirect;
   logic [AW-1:0] w_target;
   logic [AW-1:0] w_link;
   logic [AW-1:0] w_top;
   logic [CW-1:0] w_count;
   logic          w_hit;

   logic          r_out_valid;
   logic          r_jal;
   logic          r_redirect;
   logic [AW-1:0] r_target;
   logic [AW-1:0] r_link;
   logic          r_hit;

   // Flush and stall both block acceptance, so no RAS update can leak through.
   assign w_accept = in_valid && !stall && !flush;
   assign w_link   = pc + AW'(LINK_OFFSET);

   always_comb begin
      w_is_jal   = 1'b0;
      w_is_jr    = 1'b0;
      w_redirect = 1'b0;
      w_target   = '0;
      case (jb_code_t'(jump_branch))
         JB_BEQ: begin
            w_redirect = zero;
            w_target   = zero ? br_target : '0;
         end
         JB_BNE: begin
            w_redirect = !zero;
            w_target   = zero ? '0 : br_target;
         end
         JB_JR: begin
            w_is_jr    = 1'b1;
            w_redirect = 1'b1;
            w_target   = rs_val;
         end
         JB_J: begin
            w_redirect = 1'b1;
            w_target   = j_target;
         end
         JB_JAL: begin
            w_is_jal   = 1'b1;
            w_redirect = 1'b1;
            w_target   = j_target;
         end
         default: ;
      endcase
   end

   jb_ras_stack #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept && w_is_jal),
      .i_pop   (w_accept && w_is_jr),
      .i_din   (w_link),
      .o_top   (w_top),
      .o_count (w_count)
   );

   assign w_hit = w_is_jr && (w_count != '0) && (w_top == rs_val);

   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && !w_accept)) begin
         r_out_valid <= 1'b0;
         r_jal       <= 1'b0;
         r_redirect  <= 1'b0;
         r_target    <= '0;
         r_link      <= '0;
         r_hit       <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_jal       <= w_is_jal;
         r_redirect  <= w_redirect;
         r_target    <= w_target;
         r_link      <= w_is_jal ? w_link : '0;
         r_hit       <= w_hit;
      end
   end

   assign out_valid = r_out_valid;
   assign jal       = r_jal;
   assign redirect  = r_redirect;
   assign target    = r_target;
   assign link_addr = r_link;
   assign ras_hit   = r_hit;
   assign ras_count = w_count;

`ifdef JB_STATS_EN
   logic [31:0] r_redirect_cnt;
   logic [31:0] r_ras_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_cnt <= '0;
         r_ras_miss_cnt <= '0;
      end else if (w_accept) begin
         if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         if (w_is_jr && !w_hit && (r_ras_miss_cnt != 32'hFFFF_FFFF))
            r_ras_miss_cnt <= r_ras_miss_cnt + 32'd1;
      end
   end

   assign redirect_cnt = r_redirect_cnt;
   assign ras_miss_cnt = r_ras_miss_cnt;
`endif

endmodule

// File: tb/tb_jb_resolve_ras.sv
// Bench for jb_resolve_ras: queue-based reference model checked every cycle,
// plus directed literal checks. Define JB_STATS_EN to also cover the counters.
module tb_jb_resolve_ras;

   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic [2:0]    jump_branch = 3'd0;
   logic [AW-1:0] pc = '0;
   logic          zero = 1'b0;
   logic [AW-1:0] rs_val = '0;
   logic [AW-1:0] br_target = '0;
   logic [AW-1:0] j_target = '0;

   logic          out_valid, jal, redirect, ras_hit;
   logic [AW-1:0] target, link_addr;
   logic [CW-1:0] ras_count;
`ifdef JB_STATS_EN
   logic [31:0]   redirect_cnt, ras_miss_cnt;
`endif

   jb_resolve_ras #(.AW(AW), .RAS_DEPTH(DEPTH), .LINK_OFFSET(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .stall       (stall),
      .flush       (flush),
      .jump_branch (jump_branch),
      .pc          (pc),
      .zero        (zero),
      .rs_val      (rs_val),
      .br_target   (br_target),
      .j_target    (j_target),
      .out_valid   (out_valid),
      .jal         (jal),
      .redirect    (redirect),
      .target      (target),
      .link_addr   (link_addr),
      .ras_hit     (ras_hit),
      .ras_count   (ras_count)
`ifdef JB_STATS_EN
      ,
      .redirect_cnt (redirect_cnt),
      .ras_miss_cnt (ras_miss_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // reference model: RAS as a plain queue, newest at the back
   logic [AW-1:0] ras_q[$];
   logic          e_valid, e_jal, e_redirect, e_hit;
   logic [AW-1:0] e_target, e_link;
   logic [31:0]   e_rcnt, e_mcnt;

   task automatic model_update();
      logic [AW-1:0] top;
      if (rst) begin
         ras_q.delete();
         {e_valid, e_jal, e_redirect, e_hit} = '0;
         e_target = '0; e_link = '0; e_rcnt = '0; e_mcnt = '0;
      end else if (flush || (!stall && !in_valid)) begin
         {e_valid, e_jal, e_redirect, e_hit} = '0;
         e_target = '0; e_link = '0;
      end else if (!stall) begin
         e_valid = 1'b1; e_jal = 1'b0; e_hit = 1'b0; e_link = '0;
         e_redirect = 1'b0; e_target = '0;
         case (jump_branch)
            3'd1: if (zero)  begin e_redirect = 1'b1; e_target = br_target; end
            3'd2: if (!zero) begin e_redirect = 1'b1; e_target = br_target; end
            3'd3: begin
               e_redirect = 1'b1; e_target = rs_val;
               if (ras_q.size() > 0) begin
                  top = ras_q.pop_back();
                  e_hit = (top == rs_val);
               end
               if (!e_hit && e_mcnt != 32'hFFFF_FFFF) e_mcnt++;
            end
            3'd4: begin e_redirect = 1'b1; e_target = j_target; end
            3'd7: begin
               e_redirect = 1'b1; e_target = j_target; e_jal = 1'b1;
               e_link = pc + 32'd4;
               ras_q.push_back(e_link);
               if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
            default: ;
         endcase
         if (e_redirect && e_rcnt != 32'hFFFF_FFFF) e_rcnt++;
      end
   endtask

   // compare process: every negedge once reset has been applied
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 32'(out_valid), 32'(e_valid));
         check("jal",       32'(jal),       32'(e_jal));
         check("redirect",  32'(redirect),  32'(e_redirect));
         check("target",    target,         e_target);
         check("link_addr", link_addr,      e_link);
         check("ras_hit",   32'(ras_hit),   32'(e_hit));
         check("ras_count", 32'(ras_count), 32'(ras_q.size()));
`ifdef JB_STATS_EN
         check("redirect_cnt", redirect_cnt, e_rcnt);
         check("ras_miss_cnt", ras_miss_cnt, e_mcnt);
`endif
      end
   end

   // driver: apply one cycle of inputs, update model at the edge, return at negedge
   task automatic step(input logic r, input logic v, input logic s, input logic f,
                       input logic [2:0] c, input logic [AW-1:0] p, input logic z,
                       input logic [AW-1:0] rs, input logic [AW-1:0] br, input logic [AW-1:0] jt);
      rst = r; in_valid = v; stall = s; flush = f; jump_branch = c;
      pc = p; zero = z; rs_val = rs; br_target = br; j_target = jt;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 3'd0, '0, 0, '0, '0, '0);
   endtask

   task automatic jal_at(input logic [AW-1:0] p);
      step(0, 1, 0, 0, 3'd7, p, 0, '0, '0, 32'h1000);
   endtask

   task automatic jr_to(input logic [AW-1:0] rs);
      step(0, 1, 0, 0, 3'd3, '0, 0, rs, '0, '0);
   endtask

   initial begin
      @(negedge clk);
      step(1, 0, 0, 0, 3'd0, '0, 0, '0, '0, '0);
      step(1, 1, 0, 0, 3'd7, 32'h40, 0, '0, '0, 32'h1000);
      chk_en = 1'b1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(ras_count), 32'd0);

      // branches
      step(0, 1, 0, 0, 3'd1, 32'h8, 1, '0, 32'h100, '0);
      check("beq_taken_valid",  32'(out_valid), 32'd1);
      check("beq_taken_target", target, 32'h100);
      check("beq_taken_jal",    32'(jal), 32'd0);
      step(0, 1, 0, 0, 3'd1, 32'h8, 0, '0, 32'h100, '0);
      check("beq_nt_redirect", 32'(redirect), 32'd0);
      check("beq_nt_target",   target, 32'h0);
      step(0, 1, 0, 0, 3'd2, 32'hC, 0, '0, 32'h200, '0);
      check("bne_taken_target", target, 32'h200);
      step(0, 1, 0, 0, 3'd4, 32'h10, 0, '0, '0, 32'h300);
      check("j_target", target, 32'h300);
      step(0, 1, 0, 0, 3'd5, 32'h14, 1, 32'h5, 32'h6, 32'h7);
      check("code5_redirect", 32'(redirect), 32'd0);
      idle();
      check("idle_valid", 32'(out_valid), 32'd0);

      // JAL then matching JR
      jal_at(32'h40);
      check("jal_flag",  32'(jal), 32'd1);
      check("jal_link",  link_addr, 32'h44);
      check("jal_count", 32'(ras_count), 32'd1);
      jr_to(32'h44);
      check("jr_hit",    32'(ras_hit), 32'd1);
      check("jr_target", target, 32'h44);
      check("jr_count",  32'(ras_count), 32'd0);

      // overflow: five pushes into four entries
      for (int i = 1; i <= 5; i++) jal_at(32'(i * 16));
      check("full_count", 32'(ras_count), 32'd4);
      for (int i = 5; i >= 2; i--) begin
         jr_to(32'(i * 16 + 4));
         check("ovf_pop_hit", 32'(ras_hit), 32'd1);
      end
      jr_to(32'h14);
      check("ovf_lost_hit",   32'(ras_hit), 32'd0);
      check("ovf_lost_count", 32'(ras_count), 32'd0);

      // JR on empty stack, and a miss on a non-empty one
      jr_to(32'h80);
      check("empty_jr_redirect", 32'(redirect), 32'd1);
      check("empty_jr_target",   target, 32'h80);
      check("empty_jr_hit",      32'(ras_hit), 32'd0);
      jal_at(32'h10);
      jr_to(32'h99);
      check("miss_jr_hit", 32'(ras_hit), 32'd0);

      // stall holds, flush beats everything
      jal_at(32'h60);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 1, 0, 3'd7, 32'h70, 0, '0, '0, 32'h2000);
         check("stall_hold_link", link_addr, 32'h64);
      end
      step(0, 1, 0, 1, 3'd7, 32'h70, 0, '0, '0, 32'h2000);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_count", 32'(ras_count), 32'd1);
      step(0, 1, 1, 1, 3'd7, 32'h70, 0, '0, '0, 32'h2000);
      check("flush_stall_count", 32'(ras_count), 32'd1);

      // pc wrap on link
      jal_at(32'hFFFF_FFFE);
      check("wrap_link", link_addr, 32'h2);

      // reset mid-operation
      step(1, 1, 0, 0, 3'd7, 32'h80, 0, '0, '0, 32'h3000);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_count", 32'(ras_count), 32'd0);

`ifdef JB_STATS_EN
      step(0, 1, 0, 0, 3'd1, '0, 1, '0, 32'h100, '0);
      step(0, 1, 0, 0, 3'd2, '0, 0, '0, 32'h200, '0);
      step(0, 1, 1, 0, 3'd4, '0, 0, '0, '0, 32'h300);
      step(0, 1, 0, 1, 3'd4, '0, 0, '0, '0, 32'h300);
      step(0, 1, 0, 0, 3'd1, '0, 0, '0, 32'h100, '0);
      jr_to(32'h80);
      check("stats_redirect_cnt", redirect_cnt, 32'd3);
      check("stats_miss_cnt",     ras_miss_cnt, 32'd1);
      step(0, 1, 0, 0, 3'd4, '0, 0, '0, '0, 32'h300);
      check("stats_redirect_cnt4", redirect_cnt, 32'd4);
      step(1, 0, 0, 0, 3'd0, '0, 0, '0, '0, '0);
      check("stats_rst_redirect", redirect_cnt, 32'd0);
      check("stats_rst_miss",     ras_miss_cnt, 32'd0);
`endif

      idle();
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
